// File: rtl/uart_echo_fifo_if.sv
// Receiver/transmitter handshake bundle seen by uart_echo_fifo.
// The slave side is the echo block; the master side is the UART pair (or a bench).
interface uart_echo_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_ferr;
    logic                  tx_busy;
    logic                  tx_start;
    logic [DATA_WIDTH-1:0] tx_data;

    modport master (
        output rx_ready, rx_data, rx_ferr, tx_busy,
        input  tx_start, tx_data
    );

    modport slave (
        input  rx_ready, rx_data, rx_ferr, tx_busy,
        output tx_start, tx_data
    );
endinterface

// File: rtl/uart_echo_fifo.sv
// Buffers received UART words in a FIFO, applies a per-word transform at write
// time and replays them to the transmitter with a start/busy handshake.
module uart_echo_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_LOG2  = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    uart_echo_fifo_if.slave       bus,
    input  logic [1:0]            mode,
    input  logic                  clear_overflow,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int TW    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

    state_t                  state;
    logic [TW-1:0]           to_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic                    push_req, push, pop, ovf_set;

    always_comb begin
        wr_word = bus.rx_data;
        case (mode)
            2'b01:   wr_word = ~bus.rx_data;
            2'b10:   wr_word = bus.rx_data + DATA_WIDTH'(1);
            default: wr_word = bus.rx_data;
        endcase
    end

    // Pop uses the registered count, so a word written this edge is never
    // replayed on the same edge; a full FIFO still accepts when a pop frees room.
    assign pop      = (state == IDLE) && (fifo_count != '0) && !bus.tx_busy;
    assign push_req = bus.rx_ready && !bus.rx_ferr && (mode != 2'b11);
    assign push     = push_req && ((fifo_count != FULL) || pop);
    assign ovf_set  = push_req && !push;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (ovf_set)             overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            to_cnt       <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= '0;
        end else begin
            bus.tx_start <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    bus.tx_data  <= mem[rd_ptr];
                    bus.tx_start <= 1'b1;
                    state        <= START;
                end
                START: begin
                    to_cnt <= '0;
                    state  <= WAIT_ACK;
                end
                // A transmitter that never raises busy is treated as having sent the word.
                WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                        if (to_cnt + TW'(1) == TO_LAST) state <= IDLE;
                    end
                end
                WAIT_DONE: if (!bus.tx_busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: scenario tasks plus a randomized run
// compared against a queue-based model of the expected transmit stream.
module tb_uart_echo_fifo;
    localparam int DW = 8;
    localparam int DL = 4;
    localparam int AT = 4;
    localparam int BUSY_LEN = 20;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          clear_overflow = 1'b0;
    logic [DL:0]   fifo_count;
    logic          overflow;

    uart_echo_fifo_if #(.DATA_WIDTH(DW)) bus ();

    uart_echo_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .ACK_TIMEOUT(AT)) dut (
        .clock(clock), .resetn(resetn), .bus(bus), .mode(mode),
        .clear_overflow(clear_overflow), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Transmitter model: optional auto busy frame 1 cycle after each start, or held busy.
    logic        auto_en = 1'b0;
    logic        hold_busy = 1'b0;
    logic        busy_delay = 1'b0;
    int          busy_cnt = 0;
    logic [DW-1:0] got_q[$];
    int          start_cyc[$];

    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clock); #2;
            if (busy_delay) begin busy_delay = 1'b0; busy_cnt = BUSY_LEN; end
            else if (busy_cnt > 0) busy_cnt--;
            if (bus.tx_start === 1'b1) begin
                got_q.push_back(bus.tx_data);
                start_cyc.push_back(cyc);
                if (auto_en) busy_delay = 1'b1;
            end
            bus.tx_busy = hold_busy || (busy_cnt > 0);
        end
    end

    function automatic logic [DW-1:0] xform(input logic [1:0] m, input logic [DW-1:0] d);
        int v;
        v = d;
        case (m)
            2'b01:   v = 255 - v;
            2'b10:   v = (v + 1) % 256;
            default: v = d;
        endcase
        return v[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic fe);
        bus.rx_ready = 1'b1; bus.rx_data = d; bus.rx_ferr = fe;
        tick();
        bus.rx_ready = 1'b0; bus.rx_ferr = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc && got_q.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        bus.rx_ready = 1'b0; bus.rx_data = '0; bus.rx_ferr = 1'b0;
        resetn = 1'b0;
        repeat (3) tick();
        tests_run++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start got=%b exp=0", bus.tx_start); end
        tests_run++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
        tests_run++; if (fifo_count !== 5'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        resetn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_latency();
        auto_en = 1'b1; mode = 2'b00; got_q.delete();
        tests_run++; if (fifo_count !== 5'd0) begin fails++; $display("FAIL lat_count0 got=%0d exp=0", fifo_count); end
        send(8'h41, 1'b0);
        tests_run++; if (fifo_count !== 5'd1 || bus.tx_start !== 1'b0) begin
            fails++; $display("FAIL lat_n1 count=%0d start=%b exp count=1 start=0", fifo_count, bus.tx_start); end
        tick();
        tests_run++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h41 || fifo_count !== 5'd0) begin
            fails++; $display("FAIL lat_n2 start=%b data=%h count=%0d exp 1/41/0", bus.tx_start, bus.tx_data, fifo_count); end
        tick();
        tests_run++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL lat_pulse_width got=%b exp=0", bus.tx_start); end
        repeat (BUSY_LEN + 5) tick();
    endtask

    task automatic test_transform();
        logic [1:0]    ms[3] = '{2'b01, 2'b10, 2'b00};
        logic [DW-1:0] ds[3] = '{8'h0F, 8'hFF, 8'h7E};
        int n0;
        for (int i = 0; i < 3; i++) begin
            got_q.delete(); mode = ms[i];
            send(ds[i], 1'b0);
            wait_starts(1, 20);
            tests_run++;
            if (got_q.size() != 1) begin fails++; $display("FAIL xform_timeout mode=%0d no start", ms[i]); end
            else if (got_q[0] !== xform(ms[i], ds[i])) begin
                fails++; $display("FAIL xform mode=%0d got=%h exp=%h", ms[i], got_q[0], xform(ms[i], ds[i])); end
            repeat (BUSY_LEN + 5) tick();
        end
        mode = 2'b11; n0 = start_cyc.size();
        send(8'h55, 1'b0);
        repeat (10) tick();
        tests_run++; if (start_cyc.size() != n0 || fifo_count !== 5'd0 || overflow !== 1'b0) begin
            fails++; $display("FAIL mute starts=%0d count=%0d ovf=%b exp 0/0/0", start_cyc.size() - n0, fifo_count, overflow); end
        mode = 2'b00;
    endtask

    task automatic test_overflow();
        hold_busy = 1'b1; got_q.delete(); mode = 2'b00;
        repeat (2) tick();
        for (int i = 0; i < 17; i++) begin
            bus.rx_ready = 1'b1; bus.rx_data = DW'(i);
            tick();
        end
        bus.rx_ready = 1'b0;
        tests_run++; if (fifo_count !== 5'd16) begin fails++; $display("FAIL ovf_count got=%0d exp=16", fifo_count); end
        tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        tests_run++; if (got_q.size() != 0) begin fails++; $display("FAIL ovf_start_while_busy got=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_clear();
        clear_overflow = 1'b1;
        send(8'h20, 1'b0);
        clear_overflow = 1'b0;
        tests_run++; if (overflow !== 1'b1 || fifo_count !== 5'd16) begin
            fails++; $display("FAIL clear_vs_set ovf=%b count=%0d exp 1/16", overflow, fifo_count); end
        clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
        tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL clear_alone got=%b exp=0", overflow); end
        tick();
        tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL clear_sticky got=%b exp=0", overflow); end
    endtask

    task automatic test_drain();
        hold_busy = 1'b0; auto_en = 1'b1;
        wait_starts(16, 16 * (BUSY_LEN + 6) + 50);
        repeat (BUSY_LEN + 10) tick();
        tests_run++;
        if (got_q.size() != 16) begin fails++; $display("FAIL drain_size got=%0d exp=16", got_q.size()); end
        else for (int i = 0; i < 16; i++) if (got_q[i] !== DW'(i)) begin
            fails++; $display("FAIL drain_order idx=%0d got=%h exp=%h", i, got_q[i], DW'(i)); break; end
    endtask

    task automatic test_ferr_timeout();
        got_q.delete(); start_cyc.delete(); mode = 2'b00;
        send(8'h33, 1'b1);
        repeat (10) tick();
        tests_run++; if (got_q.size() != 0 || fifo_count !== 5'd0 || overflow !== 1'b0) begin
            fails++; $display("FAIL ferr starts=%0d count=%0d ovf=%b exp 0/0/0", got_q.size(), fifo_count, overflow); end
        auto_en = 1'b0;
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b0);
        wait_starts(2, 60);
        tests_run++;
        if (got_q.size() != 2) begin fails++; $display("FAIL timeout_starts got=%0d exp=2", got_q.size()); end
        else begin
            if (got_q[0] !== 8'hA5 || got_q[1] !== 8'h5A) begin
                fails++; $display("FAIL timeout_data got=%h,%h exp=a5,5a", got_q[0], got_q[1]); end
            tests_run++;
            if (start_cyc[1] - start_cyc[0] != AT + 2) begin
                fails++; $display("FAIL timeout_gap got=%0d exp=%0d", start_cyc[1] - start_cyc[0], AT + 2); end
        end
        repeat (10) tick();
    endtask

    task automatic test_reset_mid();
        int n0;
        auto_en = 1'b1; got_q.delete(); mode = 2'b00;
        for (int i = 0; i < 6; i++) send(DW'(8'h60 + i), 1'b0);
        tick();
        tests_run++; if (fifo_count !== 5'd5 || bus.tx_busy !== 1'b1) begin
            fails++; $display("FAIL rstmid_pre count=%0d busy=%b exp 5/1", fifo_count, bus.tx_busy); end
        #2 resetn = 1'b0;
        #1;
        tests_run++; if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00 || fifo_count !== 5'd0 || overflow !== 1'b0) begin
            fails++; $display("FAIL rstmid_async start=%b data=%h count=%0d ovf=%b exp 0/00/0/0",
                              bus.tx_start, bus.tx_data, fifo_count, overflow); end
        tick(); resetn = 1'b1; auto_en = 1'b0;
        n0 = got_q.size();
        repeat (40) tick();
        tests_run++; if (got_q.size() != n0 || fifo_count !== 5'd0) begin
            fails++; $display("FAIL rstmid_after starts=%0d count=%0d exp 0/0", got_q.size() - n0, fifo_count); end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] d;
        logic [1:0]    m;
        logic          fe;
        auto_en = 1'b1; got_q.delete();
        for (int i = 0; i < 12; i++) begin
            d = DW'($urandom); m = 2'($urandom_range(0, 3)); fe = ($urandom_range(0, 5) == 0);
            mode = m;
            if (!fe && m != 2'b11) exp_q.push_back(xform(m, d));
            send(d, fe);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_starts(exp_q.size(), 12 * (BUSY_LEN + 6) + 50);
        repeat (BUSY_LEN + 10) tick();
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL random_size got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) begin
            fails++; $display("FAIL random_word idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); break; end
        tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL random_overflow got=%b exp=0", overflow); end
        mode = 2'b00;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_transform();
        test_overflow();
        test_clear();
        test_drain();
        test_ferr_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
